int_ctrl: RTL and testbench

External interrupt front end for the CP0 coprocessor, sitting directly upstream of it. It synchronizes and edge-detects up to N_IRQ external request lines and latches them as pending. It selects the highest-priority pending line and sequences interrupt entry: an EPC write, a cause write, and clearing of the global enable. On `eret_i` it sequences the return by re-setting the enable bit.

---
 rtl/int_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_int_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// -----------------------------------------------------------------------------
// int_ctrl
// Interrupt front end that sits directly upstream of the CP0 coprocessor.
// Each external request line passes through a synchronizer. A rising edge on
// a line latches a pending bit. When the enable allows it, the block picks the
// lowest-index pending line and sequences interrupt entry: EPC write, cause
// write and clearing of the global enable. On eret it sequences the return by
// setting the enable again.
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   irq_i          asynchronous external requests (rising edge = event)
//   int_en_i       CP0 Enable bit 0 (global interrupt enable)
//   stall_i        pipeline cannot take a redirect this cycle
//   eret_i         one-cycle pulse, return-from-exception retiring
//   int_req_o      redirect/flush strobe to the pipeline
//   write_epc_o    CP0 WriteEPC strobe
//   write_cause_o  CP0 WriteCause strobe
//   cause_o        cause code, 5'h10 | winning index
//   write_int_o    CP0 WriteInt strobe
//   int_en_o       value written to Enable bit 0 with write_int_o
//   pending_o      current pending bits
// -----------------------------------------------------------------------------
module int_ctrl #(
    parameter int N_IRQ = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_i,
    input  logic             int_en_i,
    input  logic             stall_i,
    input  logic             eret_i,
    output logic             int_req_o,
    output logic             write_epc_o,
    output logic             write_cause_o,
    output logic [4:0]       cause_o,
    output logic             write_int_o,
    output logic             int_en_o,
    output logic [N_IRQ-1:0] pending_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENTRY  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RETURN = 2'd3
    } state_t;

    state_t           state_r;
    state_t           next_state_s;
    logic [N_IRQ-1:0] s1_r;
    logic [N_IRQ-1:0] s2_r;
    logic [N_IRQ-1:0] s3_r;
    logic [N_IRQ-1:0] rise_s;
    logic [N_IRQ-1:0] pending_r;
    logic [N_IRQ-1:0] clr_mask_s;
    logic [3:0]       win_idx_r;
    logic [4:0]       cause_r;
    logic             take_entry_s;

    // Lowest set bit wins; scanning downward leaves the smallest index.
    function automatic logic [3:0] lowest_idx(input logic [N_IRQ-1:0] vec);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 4'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // One-hot mask for a 4-bit line index.
    function automatic logic [N_IRQ-1:0] idx_mask(input logic [3:0] idx);
        logic [N_IRQ-1:0] m;
        m = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (4'(i) == idx) begin
                m[i] = 1'b1;
            end else begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

    // s1/s2 resolve metastability; s3 gives the previous level for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r <= '0;
            s2_r <= '0;
            s3_r <= '0;
        end else begin
            s1_r <= irq_i;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    assign rise_s       = s2_r & ~s3_r;
    assign clr_mask_s   = (state_r == ST_ENTRY) ? idx_mask(win_idx_r) : '0;
    assign take_entry_s = (state_r == ST_IDLE) && (next_state_s == ST_ENTRY);

    // Pending latch: the set term is ORed in after the clear, so a new edge on
    // the line being serviced survives the ENTRY cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_r <= '0;
        end else begin
            pending_r <= (pending_r & ~clr_mask_s) | rise_s;
        end
    end

    // Winner index and cause code are captured on the way into ENTRY and held.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_idx_r <= 4'd0;
            cause_r   <= 5'h00;
        end else if (take_entry_s) begin
            win_idx_r <= lowest_idx(pending_r);
            cause_r   <= {1'b1, lowest_idx(pending_r)};
        end else begin
            win_idx_r <= win_idx_r;
            cause_r   <= cause_r;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; eret takes priority over a new interrupt in IDLE.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (eret_i) begin
                    next_state_s = ST_RETURN;
                end else if ((pending_r != '0) && int_en_i && !stall_i) begin
                    next_state_s = ST_ENTRY;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ENTRY:  next_state_s = ST_WAIT;
            ST_WAIT: begin
                if (eret_i) begin
                    next_state_s = ST_RETURN;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_RETURN: next_state_s = ST_IDLE;
            default:   next_state_s = ST_IDLE;
        endcase
    end

    // Moore output decode from the state register.
    always_comb begin
        int_req_o     = 1'b0;
        write_epc_o   = 1'b0;
        write_cause_o = 1'b0;
        write_int_o   = 1'b0;
        int_en_o      = 1'b0;
        case (state_r)
            ST_ENTRY: begin
                int_req_o     = 1'b1;
                write_epc_o   = 1'b1;
                write_cause_o = 1'b1;
                write_int_o   = 1'b1;
                int_en_o      = 1'b0;
            end
            ST_RETURN: begin
                write_int_o = 1'b1;
                int_en_o    = 1'b1;
            end
            default: begin
                int_req_o = 1'b0;
            end
        endcase
    end

    assign cause_o   = cause_r;
    assign pending_o = pending_r;

endmodule

// File: tb/tb_int_ctrl.sv
// -----------------------------------------------------------------------------
// tb_int_ctrl
// Self-checking bench for int_ctrl (N_IRQ = 8). Expected CP0 strobe events
// are queued as stimulus is applied; a monitor pops and compares every cycle
// in which the DUT raises any strobe. Point checks cover reset state, pending
// bits and exact entry timing.
// -----------------------------------------------------------------------------
module tb_int_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] irq_i;
    logic       int_en_i;
    logic       stall_i;
    logic       eret_i;
    logic       int_req_o;
    logic       write_epc_o;
    logic       write_cause_o;
    logic [4:0] cause_o;
    logic       write_int_o;
    logic       int_en_o;
    logic [7:0] pending_o;

    int         vectors;
    int         miscompares;
    logic [9:0] sb[$];

    int_ctrl #(.N_IRQ(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .irq_i        (irq_i),
        .int_en_i     (int_en_i),
        .stall_i      (stall_i),
        .eret_i       (eret_i),
        .int_req_o    (int_req_o),
        .write_epc_o  (write_epc_o),
        .write_cause_o(write_cause_o),
        .cause_o      (cause_o),
        .write_int_o  (write_int_o),
        .int_en_o     (int_en_o),
        .pending_o    (pending_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Event word: {int_req, write_epc, write_cause, write_int, int_en, cause}
    function automatic logic [9:0] entry_ev(input logic [4:0] c);
        return {5'b11110, c};
    endfunction

    function automatic logic [9:0] return_ev(input logic [4:0] c);
        return {5'b00011, c};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard monitor: any strobe cycle must match the next queued event.
    always @(negedge clk) begin
        if (int_req_o | write_epc_o | write_cause_o | write_int_o) begin
            if (sb.size() == 0) begin
                check("unexpected_strobe",
                      32'({int_req_o, write_epc_o, write_cause_o, write_int_o, int_en_o, cause_o}),
                      32'd0);
            end else begin
                check("strobe_event",
                      32'({int_req_o, write_epc_o, write_cause_o, write_int_o, int_en_o, cause_o}),
                      32'(sb.pop_front()));
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst      = 1'b1;
        irq_i    = 8'h00;
        int_en_i = 1'b1;
        stall_i  = 1'b0;
        eret_i   = 1'b0;
        cyc(2);
        check("reset_outputs",
              32'({int_req_o, write_epc_o, write_cause_o, write_int_o, int_en_o, cause_o, pending_o}),
              32'd0);
        rst = 1'b0;
        cyc(1);

        // Single IRQ on line 3, high for 3 cycles
        irq_i = 8'h08;
        sb.push_back(entry_ev(5'h13));
        cyc(2);
        check("t1_no_early_entry", 32'(int_req_o), 32'd0);
        cyc(1);
        check("t1_pending", 32'(pending_o), 32'h08);
        check("t1_entry_not_yet", 32'(int_req_o), 32'd0);
        irq_i = 8'h00;
        cyc(1);
        check("t1_entry_timing", 32'(int_req_o), 32'd1);
        cyc(1);
        check("t1_pending_cleared", 32'(pending_o), 32'h00);
        eret_i = 1'b1;
        sb.push_back(return_ev(5'h13));
        cyc(1);
        eret_i = 1'b0;
        cyc(2);

        // Priority: lines 5 and 2 together
        irq_i = 8'h24;
        sb.push_back(entry_ev(5'h12));
        cyc(3);
        check("t2_pending", 32'(pending_o), 32'h24);
        irq_i = 8'h00;
        cyc(1);
        check("t2_entry1", 32'(int_req_o), 32'd1);
        cyc(1);
        check("t2_pending_left", 32'(pending_o), 32'h20);
        eret_i = 1'b1;
        sb.push_back(return_ev(5'h12));
        sb.push_back(entry_ev(5'h15));
        cyc(1);
        eret_i = 1'b0;
        cyc(1);
        check("t2_idle_gap", 32'(int_req_o), 32'd0);
        cyc(1);
        check("t2_entry2", 32'(int_req_o), 32'd1);
        cyc(1);
        check("t2_pending_empty", 32'(pending_o), 32'h00);
        eret_i = 1'b1;
        sb.push_back(return_ev(5'h15));
        cyc(1);
        eret_i = 1'b0;
        cyc(2);

        // Disabled, then stalled
        int_en_i = 1'b0;
        irq_i    = 8'h01;
        cyc(1);
        irq_i = 8'h00;
        cyc(4);
        check("t3_pending_held", 32'(pending_o), 32'h01);
        check("t3_no_entry_disabled", 32'(int_req_o), 32'd0);
        int_en_i = 1'b1;
        stall_i  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            check("t3_no_entry_stalled", 32'(int_req_o), 32'd0);
        end
        stall_i = 1'b0;
        sb.push_back(entry_ev(5'h10));
        cyc(1);
        check("t3_entry_after_stall", 32'(int_req_o), 32'd1);
        cyc(1);
        check("t3_pending_cleared", 32'(pending_o), 32'h00);
        eret_i = 1'b1;
        sb.push_back(return_ev(5'h10));
        cyc(1);
        eret_i = 1'b0;
        cyc(2);

        // Set/clear collision on line 1: second rise lands in the ENTRY cycle
        irq_i = 8'h02;
        sb.push_back(entry_ev(5'h11));
        cyc(1);
        irq_i = 8'h00;
        cyc(1);
        irq_i = 8'h02;
        cyc(1);
        check("t4_pending", 32'(pending_o), 32'h02);
        irq_i = 8'h00;
        cyc(1);
        check("t4_entry", 32'(int_req_o), 32'd1);
        cyc(1);
        check("t4_collision_kept", 32'(pending_o), 32'h02);
        eret_i = 1'b1;
        sb.push_back(return_ev(5'h11));
        sb.push_back(entry_ev(5'h11));
        cyc(1);
        eret_i = 1'b0;
        cyc(2);
        check("t4_reentry", 32'(int_req_o), 32'd1);
        cyc(1);
        check("t4_pending_cleared", 32'(pending_o), 32'h00);
        eret_i = 1'b1;
        sb.push_back(return_ev(5'h11));
        cyc(1);
        eret_i = 1'b0;
        cyc(2);

        // Reset while in WAIT with line 4 pending
        irq_i = 8'h04;
        sb.push_back(entry_ev(5'h12));
        cyc(1);
        irq_i = 8'h00;
        cyc(3);
        check("t5_entry", 32'(int_req_o), 32'd1);
        cyc(1);
        irq_i = 8'h10;
        cyc(1);
        irq_i = 8'h00;
        cyc(2);
        check("t5_pending_in_wait", 32'(pending_o), 32'h10);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check("t5_outputs_after_rst",
              32'({int_req_o, write_epc_o, write_cause_o, write_int_o, int_en_o, cause_o, pending_o}),
              32'd0);
        cyc(3);
        check("t5_still_idle",
              32'({int_req_o, write_int_o, pending_o}), 32'd0);

        // eret in IDLE with nothing pending; cause was reset to 0
        eret_i = 1'b1;
        sb.push_back(return_ev(5'h00));
        cyc(1);
        eret_i = 1'b0;
        cyc(1);
        check("t6_no_req_after_return", 32'(int_req_o), 32'd0);
        cyc(2);
        check("t6_idle_quiet", 32'({int_req_o, write_int_o, pending_o}), 32'd0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
